delay_tune_bank: RTL and testbench
==================================

Name: delay_tune_bank

Overview:
- Parametrised bank of NCH W-bit delay-tap registers, tuned from the board buttons.
- Channel selection uses DIP = DIP_BASE + channel index. BTN_N increments, BTN_S decrements and BTN_W restores the reset value.
- Successor of the fixed three-channel ad1/ad2/ad_valid tuner. Adds internal debounce, hold-to-auto-repeat, saturate-or-wrap mode, per-channel restore and readback of the selected channel.
- Outputs drive the ADC capture delay lines in the clkcomm domain.

Parameters:
- NCH, 3: number of delay channels (1..16).
- W, 4: width of each delay value (2..8).
- INIT, {4'd7,4'd0,4'd5}: packed NCH*W reset values. Channel 0 is in the LSBs.
- DIP_BASE, 8'd128: DIP code that selects channel 0.
- DEB_CYCLES, 16'd50000: cycles a synchronised button must stay stable before its debounced level changes.
- REPEAT_DELAY, 24'd10000000: hold cycles after the first step before auto-repeat starts.
- REPEAT_RATE, 24'd2000000: cycles between auto-repeat steps.
- SATURATE, 1: 1 = clamp at 0 and 2^W-1; 0 = modulo-2^W wrap.

Ports:
- RST  input  1  asynchronous reset, active-low.
- clkcomm  input  1  clock; all logic is in this domain.
- DIP  input  8  raw DIP switches; channel-select code.
- BTN_N  input  1  raw increment button, active-high.
- BTN_S  input  1  raw decrement button, active-high.
- BTN_W  input  1  raw restore button, active-high.
- delay_out  output  NCH*W  registered delay values; channel i is in bits [i*W +: W].
- sel_valid  output  1  registered; 1 when DIP selects a channel in range.
- sel_ch  output  4  registered selected channel index; 0 when not valid.
- sel_value  output  W  registered value of the selected channel; 0 when not valid.
- changed  output  1  one-cycle pulse when any channel value changes.

Behaviour:
- Reset (RST low, asynchronous):
  - delay_out = INIT; sel_valid = 0; sel_ch = 0; sel_value = 0; changed = 0.
  - All synchronisers, debounce counters and repeat FSMs are cleared.
  - Reset mid-hold aborts the repeat. After release, a button still held counts as a new press only after the full debounce time.
- Input conditioning:
  - Each button passes through a 2-FF synchroniser.
  - A per-button counter reloads on every change of the synchronised level. The debounced level takes the new value after DEB_CYCLES consecutive stable cycles.
  - DIP is registered once per cycle. It is not debounced; it is sampled when a step is issued.
- Selection: sel = DIP_reg - DIP_BASE. Selection is valid when DIP_reg >= DIP_BASE and sel < NCH. sel_* are registered one cycle after DIP_reg.
- Repeat FSM (one shared FSM, driven by dir = N xor S on the debounced levels):
  - IDLE -> FIRST on a debounced N or S rising edge while the other button is low.
  - FIRST: issue one step and load the counter with REPEAT_DELAY. Go to WAIT.
  - WAIT: count down. At 0, go to REPEAT and load REPEAT_RATE.
  - REPEAT: issue a step each time the counter reaches 0, then reload.
  - Any state -> IDLE when the debounced button is released, or when N and S are both high (no step on that cycle).
- Step application (one cycle after the step is issued):
  - Applies only when the selection is valid at the step cycle. Otherwise it is dropped and the FSM still advances.
  - Increment: v+1. With SATURATE=1, 2^W-1 stays 2^W-1. With SATURATE=0, 2^W-1 -> 0.
  - Decrement: v-1. With SATURATE=1, 0 stays 0. With SATURATE=0, 0 -> 2^W-1.
- Restore: a debounced BTN_W rising edge with a valid selection loads INIT into the selected channel. It does not auto-repeat.
- Simultaneous step and restore on the same cycle: restore wins and the step is dropped.
- A DIP change during a hold retargets later repeat steps to the new channel. Steps are not lost.
- changed pulses only when the new value differs from the old one. A saturated no-op gives no pulse.
- Latency: with button raw high before edge 0 and DEB_CYCLES=D, delay_out updates at edge D+4. That is 2 sync + D debounce + FSM + register.

Test Plan:
- Bench parameters: DEB_CYCLES=4, REPEAT_DELAY=32, REPEAT_RATE=8.
- Reset state: after reset, delay_out = {7,0,5}, changed = 0 and sel_valid = 0 with DIP = 0.
- Single step and latency: DIP = 128, BTN_N pulsed for 10 cycles. Channel 0 goes 5 -> 6 exactly at edge 8 with one changed pulse. A 2-cycle glitch on BTN_N gives no change.
- Auto-repeat: DIP = 129, BTN_S held 100 cycles with channel 1 at 0 and SATURATE=1. It stays 0 with no changed pulse. Then BTN_N held 100 cycles: 1 at first step, +1 every 8 cycles after 32.
- Wrap: SATURATE=0, channel 2 = 15, one BTN_N step -> 0. Channel 2 = 0, one BTN_S step -> 15.
- Conflicts: BTN_N and BTN_S both high -> no steps. DIP = 131 (NCH=3) with BTN_N -> no change and sel_valid = 0. BTN_W on channel 0 = 12 -> 5. BTN_W together with an N step -> restore value.
- Reset during hold: RST low mid-REPEAT, then high with BTN_N still held. Values return to INIT. The first new step comes only after the debounce time and counts as a fresh FIRST.

Source files
------------

// File: rtl/delay_tune_bank.sv
// Bank of NCH button-tuned delay-tap registers with debounce, hold-to-repeat,
// per-channel restore and readback of the DIP-selected channel.
module delay_tune_bank #(
  parameter int unsigned      NCH          = 3,
  parameter int unsigned      W            = 4,
  parameter logic [NCH*W-1:0] INIT         = {4'd7, 4'd0, 4'd5},
  parameter logic [7:0]       DIP_BASE     = 8'd128,
  parameter logic [15:0]      DEB_CYCLES   = 16'd50000,
  parameter logic [23:0]      REPEAT_DELAY = 24'd10000000,
  parameter logic [23:0]      REPEAT_RATE  = 24'd2000000,
  parameter bit               SATURATE     = 1'b1
) (
  input  logic             RST,
  input  logic             clkcomm,
  input  logic [7:0]       DIP,
  input  logic             BTN_N,
  input  logic             BTN_S,
  input  logic             BTN_W,
  output logic [NCH*W-1:0] delay_out,
  output logic             sel_valid,
  output logic [3:0]       sel_ch,
  output logic [W-1:0]     sel_value,
  output logic             changed
);

  localparam int unsigned NBTN = 3;
  localparam int unsigned BN   = 0;
  localparam int unsigned BS   = 1;
  localparam int unsigned BW   = 2;
  localparam logic [15:0] DEB_LOAD   = (DEB_CYCLES == 16'd0) ? 16'd0 : DEB_CYCLES - 16'd1;
  localparam logic [23:0] DELAY_LOAD = (REPEAT_DELAY == 24'd0) ? 24'd0 : REPEAT_DELAY - 24'd1;
  localparam logic [23:0] RATE_LOAD  = (REPEAT_RATE == 24'd0) ? 24'd0 : REPEAT_RATE - 24'd1;
  localparam logic [W-1:0] VMAX      = {W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_WAIT, S_REPEAT} state_t;

  logic [NBTN-1:0] btn_raw, sync1, sync2, deb, deb_q;
  logic [15:0]     deb_cnt [NBTN];

  assign btn_raw = {BTN_W, BTN_S, BTN_N};

  // Synchronise, then accept a new level only after DEB_CYCLES stable cycles
  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < NBTN; i++) deb_cnt[i] <= DEB_LOAD;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= DEB_LOAD;
        end else if (deb_cnt[i] == 16'd0) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= DEB_LOAD;
        end else begin
          deb_cnt[i] <= deb_cnt[i] - 16'd1;
        end
      end
    end
  end

  logic       n_rise_c, s_rise_c, w_rise_c;
  assign n_rise_c = deb[BN] & ~deb_q[BN];
  assign s_rise_c = deb[BS] & ~deb_q[BS];
  assign w_rise_c = deb[BW] & ~deb_q[BW];

  logic [7:0]   dip_reg, sel_diff_c;
  logic         sel_ok_c;
  logic [3:0]   sel_idx_c;
  logic [W-1:0] sel_cur_c;

  always_comb begin
    sel_diff_c = dip_reg - DIP_BASE;
    sel_ok_c   = (dip_reg >= DIP_BASE) && (sel_diff_c < 8'(NCH));
    sel_idx_c  = sel_ok_c ? sel_diff_c[3:0] : 4'd0;
    sel_cur_c  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_idx_c == 4'(i)) sel_cur_c = delay_out[i*W +: W];
    end
  end

  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      dip_reg   <= '0;
      sel_valid <= 1'b0;
      sel_ch    <= '0;
      sel_value <= '0;
    end else begin
      dip_reg   <= DIP;
      sel_valid <= sel_ok_c;
      sel_ch    <= sel_idx_c;
      sel_value <= sel_ok_c ? sel_cur_c : '0;
    end
  end

  state_t      state, state_nx;
  logic [23:0] rpt_cnt, rpt_cnt_nx;
  logic        dir_inc, dir_inc_nx, step_c, abort_c;

  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      rpt_cnt <= '0;
      dir_inc <= 1'b0;
    end else begin
      state   <= state_nx;
      rpt_cnt <= rpt_cnt_nx;
      dir_inc <= dir_inc_nx;
    end
  end

  // Shared repeat FSM; abort on release of the held button or on N+S together
  always_comb begin
    state_nx   = state;
    rpt_cnt_nx = rpt_cnt;
    dir_inc_nx = dir_inc;
    step_c     = 1'b0;
    abort_c    = (deb[BN] & deb[BS]) | (dir_inc ? ~deb[BN] : ~deb[BS]);
    case (state)
      S_IDLE: begin
        if (n_rise_c && !deb[BS]) begin
          state_nx   = S_FIRST;
          dir_inc_nx = 1'b1;
        end else if (s_rise_c && !deb[BN]) begin
          state_nx   = S_FIRST;
          dir_inc_nx = 1'b0;
        end
      end
      S_FIRST: begin
        if (abort_c) begin
          state_nx = S_IDLE;
        end else begin
          step_c     = 1'b1;
          rpt_cnt_nx = DELAY_LOAD;
          state_nx   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort_c) begin
          state_nx = S_IDLE;
        end else if (rpt_cnt == 24'd0) begin
          rpt_cnt_nx = RATE_LOAD;
          state_nx   = S_REPEAT;
        end else begin
          rpt_cnt_nx = rpt_cnt - 24'd1;
        end
      end
      S_REPEAT: begin
        if (abort_c) begin
          state_nx = S_IDLE;
        end else if (rpt_cnt == 24'd0) begin
          step_c     = 1'b1;
          rpt_cnt_nx = RATE_LOAD;
        end else begin
          rpt_cnt_nx = rpt_cnt - 24'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  logic       rest_pend, rest_q, step_q, step_inc_q;
  logic [3:0] ch_q;

  // Restore is delayed one extra cycle so it lands on the same edge as a step
  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      rest_pend  <= 1'b0;
      rest_q     <= 1'b0;
      step_q     <= 1'b0;
      step_inc_q <= 1'b0;
      ch_q       <= '0;
    end else begin
      rest_pend  <= w_rise_c;
      rest_q     <= rest_pend & sel_valid;
      step_q     <= step_c & sel_valid;
      step_inc_q <= dir_inc;
      ch_q       <= sel_ch;
    end
  end

  logic [NCH*W-1:0] dout_nx_c;
  logic [W-1:0]     step_old_c, step_new_c;

  always_comb begin
    dout_nx_c  = delay_out;
    step_old_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_q == 4'(i)) step_old_c = delay_out[i*W +: W];
    end
    if (step_inc_q) step_new_c = (SATURATE && step_old_c == VMAX) ? VMAX : step_old_c + W'(1);
    else            step_new_c = (SATURATE && step_old_c == '0) ? '0 : step_old_c - W'(1);
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_q == 4'(i)) begin
        if (rest_q)      dout_nx_c[i*W +: W] = INIT[i*W +: W];
        else if (step_q) dout_nx_c[i*W +: W] = step_new_c;
      end
    end
  end

  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      delay_out <= INIT;
      changed   <= 1'b0;
    end else begin
      delay_out <= dout_nx_c;
      changed   <= (dout_nx_c != delay_out);
    end
  end

endmodule

// File: tb/tb_delay_tune_bank.sv
// Bench for delay_tune_bank: saturating and wrapping instances, table-driven
// button vectors and a queue of expected change events per instance.
module tb_delay_tune_bank;

  localparam int D     = 4;
  localparam int RDLY  = 32;
  localparam int RRATE = 8;
  localparam logic [11:0] INIT_S = {4'd7, 4'd0, 4'd5};
  localparam logic [11:0] INIT_W = {4'd15, 4'd0, 4'd5};

  logic clkcomm = 1'b0;
  logic RST;
  logic [7:0] dip, dip2;
  logic btn_n, btn_s, btn_w, btn_n2, btn_s2, btn_w2;
  logic [11:0] dout_s, dout_w;
  logic sel_valid_s, sel_valid_w, changed_s, changed_w;
  logic [3:0] sel_ch_s, sel_ch_w, sel_value_s, sel_value_w;

  delay_tune_bank #(
    .NCH(3), .W(4), .INIT(INIT_S), .DIP_BASE(8'd128), .DEB_CYCLES(16'd4),
    .REPEAT_DELAY(24'd32), .REPEAT_RATE(24'd8), .SATURATE(1'b1)
  ) dut_s (
    .RST(RST), .clkcomm(clkcomm), .DIP(dip), .BTN_N(btn_n), .BTN_S(btn_s),
    .BTN_W(btn_w), .delay_out(dout_s), .sel_valid(sel_valid_s),
    .sel_ch(sel_ch_s), .sel_value(sel_value_s), .changed(changed_s)
  );

  delay_tune_bank #(
    .NCH(3), .W(4), .INIT(INIT_W), .DIP_BASE(8'd128), .DEB_CYCLES(16'd4),
    .REPEAT_DELAY(24'd32), .REPEAT_RATE(24'd8), .SATURATE(1'b0)
  ) dut_w (
    .RST(RST), .clkcomm(clkcomm), .DIP(dip2), .BTN_N(btn_n2), .BTN_S(btn_s2),
    .BTN_W(btn_w2), .delay_out(dout_w), .sel_valid(sel_valid_w),
    .sel_ch(sel_ch_w), .sel_value(sel_value_w), .changed(changed_w)
  );

  always #5 clkcomm = ~clkcomm;

  int cyc = 0;
  always @(posedge clkcomm) cyc <= cyc + 1;

  typedef struct {
    int          edge_no;
    logic [11:0] value;
  } ev_t;

  typedef struct {
    logic [7:0]  dip;
    logic        n, s, w;
    int          hold;
    logic [11:0] exp_dout;
    logic        exp_valid;
    logic [3:0]  exp_ch;
    logic [3:0]  exp_val;
  } vec_t;

  ev_t  sb_s[$];
  ev_t  sb_w[$];
  ev_t  ev_s, ev_w;
  vec_t vecs[11];
  logic [3:0] m_val [3];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] model_pack();
    return {m_val[2], m_val[1], m_val[0]};
  endfunction

  task automatic model_step(input int ch, input logic inc, input int edge_no);
    logic [3:0] nv;
    if (inc) nv = (m_val[ch] == 4'd15) ? 4'd15 : m_val[ch] + 4'd1;
    else     nv = (m_val[ch] == 4'd0) ? 4'd0 : m_val[ch] - 4'd1;
    if (nv != m_val[ch]) begin
      m_val[ch] = nv;
      sb_s.push_back('{edge_no, model_pack()});
    end
  endtask

  task automatic model_restore(input int ch, input int edge_no);
    logic [3:0] nv;
    logic [11:0] init_v;
    init_v = INIT_S;
    nv = init_v[ch*4 +: 4];
    if (nv != m_val[ch]) begin
      m_val[ch] = nv;
      sb_s.push_back('{edge_no, model_pack()});
    end
  endtask

  // Change-event monitor, sampled just after each active edge
  always @(posedge clkcomm) begin
    #1;
    if (changed_s === 1'b1) begin
      if (sb_s.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change_s: cycle %0d delay_out %0h, none expected", cyc, dout_s);
      end else begin
        ev_s = sb_s.pop_front();
        check("change_edge_s", 32'(cyc), 32'(ev_s.edge_no));
        check("change_value_s", 32'(dout_s), 32'(ev_s.value));
      end
    end
    if (changed_w === 1'b1) begin
      if (sb_w.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_change_w: cycle %0d delay_out %0h, none expected", cyc, dout_w);
      end else begin
        ev_w = sb_w.pop_front();
        check("change_edge_w", 32'(cyc), 32'(ev_w.edge_no));
        check("change_value_w", 32'(dout_w), 32'(ev_w.value));
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    int   t0, e, last, ch;
    logic valid;
    dip = v.dip;
    repeat (3) @(negedge clkcomm);
    valid = (v.dip >= 8'd128) && ((v.dip - 8'd128) < 8'd3);
    ch    = int'(v.dip) - 128;
    t0    = cyc + 1;
    last  = v.hold + D + 2;
    if (valid && v.hold >= D) begin
      if (v.w) model_restore(ch, t0 + D + 4);
      else if (v.n ^ v.s) model_step(ch, v.n, t0 + D + 4);
      if (v.n ^ v.s) begin
        e = D + 4 + RDLY + RRATE;
        while (e <= last) begin
          model_step(ch, v.n, t0 + e);
          e += RRATE;
        end
      end
    end
    btn_n = v.n;
    btn_s = v.s;
    btn_w = v.w;
    repeat (v.hold) @(negedge clkcomm);
    btn_n = 1'b0;
    btn_s = 1'b0;
    btn_w = 1'b0;
    repeat (2 * D + 20) @(negedge clkcomm);
    check($sformatf("vec%0d_dout", idx), 32'(dout_s), 32'(v.exp_dout));
    check($sformatf("vec%0d_model", idx), 32'(dout_s), 32'(model_pack()));
    check($sformatf("vec%0d_sel_valid", idx), 32'(sel_valid_s), 32'(v.exp_valid));
    check($sformatf("vec%0d_sel_ch", idx), 32'(sel_ch_s), 32'(v.exp_ch));
    check($sformatf("vec%0d_sel_value", idx), 32'(sel_value_s), 32'(v.exp_val));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t1;
    //          dip     n     s     w     hold  dout     vld   ch    val
    vecs[0]  = '{8'd128, 1'b1, 1'b0, 1'b0, 10,  12'h706, 1'b1, 4'd0, 4'd6};
    vecs[1]  = '{8'd128, 1'b1, 1'b0, 1'b0, 2,   12'h706, 1'b1, 4'd0, 4'd6};
    vecs[2]  = '{8'd129, 1'b0, 1'b1, 1'b0, 100, 12'h706, 1'b1, 4'd1, 4'd0};
    vecs[3]  = '{8'd129, 1'b1, 1'b0, 1'b0, 100, 12'h796, 1'b1, 4'd1, 4'd9};
    vecs[4]  = '{8'd131, 1'b1, 1'b0, 1'b0, 10,  12'h796, 1'b0, 4'd0, 4'd0};
    vecs[5]  = '{8'd128, 1'b1, 1'b1, 1'b0, 50,  12'h796, 1'b1, 4'd0, 4'd6};
    vecs[6]  = '{8'd130, 1'b0, 1'b1, 1'b0, 10,  12'h696, 1'b1, 4'd2, 4'd6};
    vecs[7]  = '{8'd128, 1'b1, 1'b0, 1'b0, 77,  12'h69C, 1'b1, 4'd0, 4'd12};
    vecs[8]  = '{8'd128, 1'b0, 1'b0, 1'b1, 10,  12'h695, 1'b1, 4'd0, 4'd5};
    vecs[9]  = '{8'd128, 1'b1, 1'b0, 1'b0, 10,  12'h696, 1'b1, 4'd0, 4'd6};
    vecs[10] = '{8'd128, 1'b1, 1'b0, 1'b1, 10,  12'h695, 1'b1, 4'd0, 4'd5};

    m_val[0] = 4'd5;
    m_val[1] = 4'd0;
    m_val[2] = 4'd7;
    RST = 1'b0;
    dip = 8'd0;  btn_n = 1'b0;  btn_s = 1'b0;  btn_w = 1'b0;
    dip2 = 8'd0; btn_n2 = 1'b0; btn_s2 = 1'b0; btn_w2 = 1'b0;

    repeat (3) @(negedge clkcomm);
    check("reset_dout_s", 32'(dout_s), 32'(INIT_S));
    check("reset_dout_w", 32'(dout_w), 32'(INIT_W));
    check("reset_changed", 32'(changed_s), 32'd0);
    check("reset_sel_valid", 32'(sel_valid_s), 32'd0);
    RST = 1'b1;
    repeat (4) @(negedge clkcomm);
    check("dip0_sel_valid", 32'(sel_valid_s), 32'd0);
    check("dip0_sel_value", 32'(sel_value_s), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a REPEAT hold on channel 0 (currently 5)
    t1 = cyc + 1;
    sb_s.push_back('{t1 + 8,  12'h696});
    sb_s.push_back('{t1 + 48, 12'h697});
    sb_s.push_back('{t1 + 56, 12'h698});
    btn_n = 1'b1;
    repeat (60) @(negedge clkcomm);
    check("pre_reset_dout", 32'(dout_s), 32'h698);
    RST = 1'b0;
    #1;
    check("mid_reset_dout", 32'(dout_s), 32'(INIT_S));
    check("mid_reset_sel_valid", 32'(sel_valid_s), 32'd0);
    check("mid_reset_changed", 32'(changed_s), 32'd0);
    repeat (3) @(negedge clkcomm);
    RST = 1'b1;
    m_val[0] = 4'd5;
    m_val[1] = 4'd0;
    m_val[2] = 4'd7;
    t1 = cyc + 1;
    sb_s.push_back('{t1 + 8, 12'h706});
    repeat (7) @(negedge clkcomm);
    check("post_reset_edge6", 32'(dout_s), 32'(INIT_S));
    repeat (13) @(negedge clkcomm);
    btn_n = 1'b0;
    repeat (40) @(negedge clkcomm);
    check("post_reset_dout", 32'(dout_s), 32'h706);

    // Modulo wrap on the SATURATE=0 instance, channel 2 starting at 15
    dip2 = 8'd130;
    repeat (3) @(negedge clkcomm);
    t1 = cyc + 1;
    sb_w.push_back('{t1 + D + 4, 12'h005});
    btn_n2 = 1'b1;
    repeat (10) @(negedge clkcomm);
    btn_n2 = 1'b0;
    repeat (30) @(negedge clkcomm);
    check("wrap_up_dout", 32'(dout_w), 32'h005);
    check("wrap_up_sel_value", 32'(sel_value_w), 32'd0);
    t1 = cyc + 1;
    sb_w.push_back('{t1 + D + 4, 12'hF05});
    btn_s2 = 1'b1;
    repeat (10) @(negedge clkcomm);
    btn_s2 = 1'b0;
    repeat (30) @(negedge clkcomm);
    check("wrap_down_dout", 32'(dout_w), 32'hF05);
    check("wrap_down_sel_value", 32'(sel_value_w), 32'd15);

    check("sb_s_drained", 32'(sb_s.size()), 32'd0);
    check("sb_w_drained", 32'(sb_w.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
